jk_reg_bank: RTL and testbench

JK_REG_BANK -- requirements
Module: jk_reg_bank

---
 rtl/jk_reg_bank.sv | 46 ++++
 tb/tb_jk_reg_bank.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/jk_reg_bank.sv
// jk_reg_bank: bank of JK cells with count, shift and parallel-load modes.
module jk_reg_bank #(
    parameter int WIDTH = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] d,
    input  logic             dir,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             ser_out,
    output logic             tc,
    output logic             chg
);
    logic [WIDTH-1:0] jk_nxt;
    logic [WIDTH-1:0] cnt_nxt;
    logic [WIDTH-1:0] shf_nxt;
    logic [WIDTH-1:0] nxt;
    always_comb begin
        jk_nxt  = (j & ~q) | (~k & q);
        cnt_nxt = dir ? q + WIDTH'(1) : q - WIDTH'(1);
        shf_nxt = dir ? {q[WIDTH-2:0], ser_in} : {ser_in, q[WIDTH-1:1]};
        nxt     = !en ? q :
                  mode == 2'b00 ? jk_nxt :
                  mode == 2'b01 ? cnt_nxt :
                  mode == 2'b10 ? shf_nxt : d;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q   <= RST_VAL;
            chg <= 1'b0;
        end else begin
            q   <= nxt;
            chg <= nxt != q;
        end
    end
    assign qn      = ~q;
    assign ser_out = dir ? q[WIDTH-1] : q[0];
    assign tc      = mode == 2'b01 && (dir ? &q : ~|q);
endmodule

// File: tb/tb_jk_reg_bank.sv
// tb_jk_reg_bank: directed scoreboard bench for jk_reg_bank (WIDTH=8, RST_VAL=0).
module tb_jk_reg_bank;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] j = '0;
    logic [7:0] k = '0;
    logic [7:0] d = '0;
    logic       dir = 1'b0;
    logic       ser_in = 1'b0;
    logic [7:0] q;
    logic [7:0] qn;
    logic       ser_out;
    logic       tc;
    logic       chg;

    typedef struct {
        logic [7:0] q;
        logic       chg;
    } exp_t;
    exp_t sb[$];
    logic [7:0] mq = 8'h00;
    int checks = 0;
    int errors = 0;

    jk_reg_bank #(.WIDTH(8), .RST_VAL(8'h00)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .j(j), .k(k), .d(d),
        .dir(dir), .ser_in(ser_in), .q(q), .qn(qn), .ser_out(ser_out),
        .tc(tc), .chg(chg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model(input logic [7:0] cq);
        logic [7:0] r;
        r = cq;
        if (en) begin
            case (mode)
                2'b00: for (int i = 0; i < 8; i++)
                    case ({j[i], k[i]})
                        2'b10: r[i] = 1'b1;
                        2'b01: r[i] = 1'b0;
                        2'b11: r[i] = ~cq[i];
                        default: r[i] = cq[i];
                    endcase
                2'b01: r = dir ? cq + 8'd1 : cq - 8'd1;
                2'b10: r = dir ? {cq[6:0], ser_in} : {ser_in, cq[7:1]};
                default: r = d;
            endcase
        end
        return r;
    endfunction

    task automatic set_in(input logic e, input logic [1:0] m, input logic [7:0] jj,
                          input logic [7:0] kk, input logic [7:0] dd, input logic dr,
                          input logic si);
        en = e; mode = m; j = jj; k = kk; d = dd; dir = dr; ser_in = si;
    endtask

    task automatic tick(input string tag);
        exp_t e;
        logic [7:0] nq;
        nq = model(mq);
        sb.push_back('{nq, nq != mq});
        mq = nq;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, "_q"}, q, e.q);
        chk({tag, "_qn"}, qn, ~e.q);
        chk({tag, "_chg"}, {7'b0, chg}, {7'b0, e.chg});
    endtask

    initial begin
        #3;
        chk("rst_q", q, 8'h00);
        chk("rst_qn", qn, 8'hFF);
        chk("rst_chg", {7'b0, chg}, 8'h00);
        set_in(1, 2'b11, 8'h00, 8'h00, 8'h5A, 0, 0);
        @(posedge clk);
        #1;
        chk("rst_edge_q", q, 8'h00);
        rst = 1'b1;
        // JK mode
        set_in(1, 2'b00, 8'hF0, 8'h00, 8'h00, 0, 0);
        tick("jk_set");
        chk("jk_set_const", q, 8'hF0);
        set_in(1, 2'b00, 8'hFF, 8'hFF, 8'h00, 0, 0);
        tick("jk_tog");
        chk("jk_tog_const", q, 8'h0F);
        set_in(1, 2'b00, 8'h00, 8'h00, 8'h00, 0, 0);
        tick("jk_hold");
        chk("jk_hold_chg", {7'b0, chg}, 8'h00);
        set_in(1, 2'b00, 8'h3C, 8'hA5, 8'h00, 0, 0);
        tick("jk_mix");
        chk("jk_mix_const", q, 8'h3A);
        chk("jk_tc", {7'b0, tc}, 8'h00);
        // count mode with wrap both ways
        set_in(1, 2'b11, 8'h00, 8'h00, 8'hFE, 0, 0);
        tick("ld_fe");
        set_in(1, 2'b01, 8'h00, 8'h00, 8'h00, 1, 0);
        chk("tc_fe", {7'b0, tc}, 8'h00);
        tick("up_ff");
        chk("tc_ff", {7'b0, tc}, 8'h01);
        en = 1'b0;
        #1 chk("tc_en0", {7'b0, tc}, 8'h01);
        mode = 2'b00;
        #1 chk("tc_mode0", {7'b0, tc}, 8'h00);
        set_in(1, 2'b01, 8'h00, 8'h00, 8'h00, 1, 0);
        tick("up_wrap");
        chk("up_wrap_const", q, 8'h00);
        dir = 1'b0;
        #1 chk("tc_zero_dn", {7'b0, tc}, 8'h01);
        tick("dn_wrap");
        chk("dn_wrap_const", q, 8'hFF);
        // shift mode
        set_in(1, 2'b11, 8'h00, 8'h00, 8'h81, 0, 0);
        tick("ld_81");
        set_in(1, 2'b10, 8'h00, 8'h00, 8'h00, 1, 0);
        #1 chk("ser_out_l", {7'b0, ser_out}, 8'h01);
        tick("shl");
        chk("shl_const", q, 8'h02);
        chk("ser_out_l0", {7'b0, ser_out}, 8'h00);
        set_in(1, 2'b10, 8'h00, 8'h00, 8'h00, 0, 1);
        tick("shr");
        chk("shr_const", q, 8'h81);
        chk("ser_out_r", {7'b0, ser_out}, 8'h01);
        // load with enable gating
        set_in(0, 2'b11, 8'h00, 8'h00, 8'hA5, 0, 0);
        tick("ld_en0");
        chk("ld_en0_const", q, 8'h81);
        en = 1'b1;
        tick("ld_a5");
        chk("ld_a5_const", q, 8'hA5);
        tick("ld_same");
        chk("ld_same_chg", {7'b0, chg}, 8'h00);
        // reset mid-count
        set_in(1, 2'b11, 8'h00, 8'h00, 8'h10, 0, 0);
        tick("ld_10");
        set_in(1, 2'b01, 8'h00, 8'h00, 8'h00, 1, 0);
        tick("up_11");
        #2 rst = 1'b0;
        #1;
        chk("arst_q", q, 8'h00);
        chk("arst_qn", qn, 8'hFF);
        chk("arst_chg", {7'b0, chg}, 8'h00);
        mq = 8'h00;
        @(posedge clk);
        #1;
        chk("arst_edge_q", q, 8'h00);
        #2 rst = 1'b1;
        #1 chk("rel_q", q, 8'h00);
        tick("rel_up");
        chk("rel_up_const", q, 8'h01);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
